jellyvl_etherneco_packet_tx_gen: RTL and testbench

- Generalised EtherNeco frame transmitter; successor to the fixed-format packet TX.
- Builds the frame: preamble, SFD, length field, parametrised header bytes, streamed payload, zero padding (short payload and minimum size), optional CRC-32 FCS.
- Drives a byte stream with first/last/error markers into the ring MAC/PHY output path.
- New relative to the previous block: configurable preamble and header length, minimum-payload padding, FCS on/off, explicit error flag, busy/done status.

---
 rtl/jellyvl_etherneco_packet_tx_gen.sv | 241 ++++++++++++++++++++++++
 tb/tb_jellyvl_etherneco_packet_tx_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jellyvl_etherneco_packet_tx_gen.sv
// EtherNeco frame transmitter: preamble, SFD, length, header, streamed payload,
// zero padding and optional CRC-32 FCS onto a valid/ready byte stream.
module jellyvl_etherneco_packet_tx_gen #(
  parameter int unsigned PREAMBLE_LEN = 6,
  parameter int unsigned HEADER_BYTES = 2,
  parameter int unsigned LENGTH_WIDTH = 16,
  parameter int unsigned MIN_PAYLOAD  = 0,
  parameter int unsigned FCS_ENABLE   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cancel,
  input  logic [LENGTH_WIDTH-1:0]   param_length,
  input  logic [HEADER_BYTES*8-1:0] param_header,
  output logic                      tx_start,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_payload_last,
  input  logic [7:0]                s_payload_data,
  input  logic                      s_payload_valid,
  output logic                      s_payload_ready,
  output logic                      m_tx_first,
  output logic                      m_tx_last,
  output logic                      m_tx_error,
  output logic [7:0]                m_tx_data,
  output logic                      m_tx_valid,
  input  logic                      m_tx_ready
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_LENGTH   = 3'd2;
  localparam logic [2:0] ST_HEADER   = 3'd3;
  localparam logic [2:0] ST_PAYLOAD  = 3'd4;
  localparam logic [2:0] ST_PAD      = 3'd5;
  localparam logic [2:0] ST_FCS      = 3'd6;

  localparam logic [16:0] MIN_P    = 17'(MIN_PAYLOAD);
  localparam logic [16:0] PRE_LEN  = 17'(PREAMBLE_LEN);
  localparam logic [16:0] HDR_LAST = 17'(HEADER_BYTES - 1);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    logic [7:0]  dd;
    v  = c;
    dd = d;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[31] ^ dd[7]) v = {v[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else               v = {v[30:0], 1'b0};
      dd = {dd[6:0], 1'b0};
    end
    return v;
  endfunction

  logic [2:0]                r_state;
  logic [16:0]               r_cnt;
  logic [15:0]               r_len;
  logic [HEADER_BYTES*8-1:0] r_hdr;
  logic [16:0]               r_n;
  logic [16:0]               r_plen;
  logic [31:0]               r_crc;
  logic                      r_valid;
  logic                      r_first;
  logic                      r_last;
  logic                      r_error;
  logic [7:0]                r_data;
  logic                      r_done;

  logic        w_cke;
  logic [16:0] w_sent;
  logic [16:0] w_n_in;
  logic [16:0] w_p_in;
  logic        w_final;
  logic        w_abort;

  assign w_cke  = !r_valid || m_tx_ready;
  assign w_sent = r_cnt + 17'd1;
  assign w_n_in = {1'b0, 16'(param_length)} + 17'd1;
  assign w_p_in = (w_n_in > MIN_P) ? w_n_in : MIN_P;

  assign tx_start        = start && !cancel && (r_state == ST_IDLE) && w_cke;
  assign s_payload_ready = w_cke && (r_state == ST_PAYLOAD);
  assign busy            = (r_state != ST_IDLE) || r_valid;
  assign done            = r_done;
  assign m_tx_valid      = r_valid;
  assign m_tx_first      = r_first;
  assign m_tx_last       = r_last;
  assign m_tx_error      = r_error;
  assign m_tx_data       = r_data;

  // w_final marks the cycle the closing beat is produced; cancel is ignored then.
  always_comb begin
    w_final = 1'b0;
    if (r_state == ST_FCS) begin
      w_final = (r_cnt == 17'd3);
    end else if (FCS_ENABLE == 0) begin
      if (r_state == ST_PAYLOAD)
        w_final = s_payload_valid && s_payload_last && (w_sent == r_n) && (r_plen == r_n);
      else if (r_state == ST_PAD)
        w_final = (w_sent == r_plen);
    end
    w_abort = 1'b0;
    if (r_state != ST_IDLE) begin
      if (cancel && !w_final) w_abort = 1'b1;
      if ((r_state == ST_PAYLOAD) &&
          (!s_payload_valid || ((w_sent == r_n) && !s_payload_last))) w_abort = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_hdr   <= '0;
      r_n     <= '0;
      r_plen  <= '0;
      r_crc   <= '1;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_error <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_valid && m_tx_ready && r_last && !r_error;
      if (w_cke) begin
        r_valid <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
        r_error <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (tx_start) begin
              r_len   <= 16'(param_length);
              r_hdr   <= param_header;
              r_n     <= w_n_in;
              r_plen  <= w_p_in;
              r_valid <= 1'b1;
              r_first <= 1'b1;
              r_data  <= 8'h55;
              r_cnt   <= 17'd1;
              r_state <= ST_PREAMBLE;
            end
          end
          ST_PREAMBLE: begin
            r_valid <= 1'b1;
            if (r_cnt < PRE_LEN) begin
              r_data <= 8'h55;
              r_cnt  <= w_sent;
            end else begin
              r_data  <= 8'hD5;
              r_cnt   <= '0;
              r_state <= ST_LENGTH;
            end
          end
          ST_LENGTH: begin
            r_valid <= 1'b1;
            if (r_cnt == 17'd0) begin
              r_data <= r_len[7:0];
              r_crc  <= crc_byte('1, r_len[7:0]);
              r_cnt  <= w_sent;
            end else begin
              r_data  <= r_len[15:8];
              r_crc   <= crc_byte(r_crc, r_len[15:8]);
              r_cnt   <= '0;
              r_state <= ST_HEADER;
            end
          end
          ST_HEADER: begin
            r_valid <= 1'b1;
            r_data  <= r_hdr[7:0];
            r_crc   <= crc_byte(r_crc, r_hdr[7:0]);
            r_hdr   <= r_hdr >> 8;
            if (r_cnt == HDR_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_PAYLOAD;
            end else begin
              r_cnt <= w_sent;
            end
          end
          ST_PAYLOAD: begin
            r_valid <= 1'b1;
            r_data  <= s_payload_data;
            r_crc   <= crc_byte(r_crc, s_payload_data);
            r_cnt   <= w_sent;
            // Early last and short frames both fall through to PAD, which fills up to r_plen.
            if (s_payload_last || (w_sent == r_n)) begin
              if (w_sent < r_plen) begin
                r_state <= ST_PAD;
              end else if (FCS_ENABLE != 0) begin
                r_cnt   <= '0;
                r_state <= ST_FCS;
              end else begin
                r_last  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_PAD: begin
            r_valid <= 1'b1;
            r_data  <= 8'h00;
            r_crc   <= crc_byte(r_crc, 8'h00);
            r_cnt   <= w_sent;
            if (w_sent == r_plen) begin
              if (FCS_ENABLE != 0) begin
                r_cnt   <= '0;
                r_state <= ST_FCS;
              end else begin
                r_last  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_FCS: begin
            r_valid <= 1'b1;
            r_data  <= r_crc[7:0];
            r_crc   <= {8'h00, r_crc[31:8]};
            if (r_cnt == 17'd3) begin
              r_last  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= w_sent;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_abort) begin
          r_valid <= 1'b1;
          r_first <= 1'b0;
          r_data  <= 8'h00;
          r_last  <= 1'b1;
          r_error <= 1'b1;
          r_state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_tx_gen.sv
// Bench for jellyvl_etherneco_packet_tx_gen: a default instance and a padded,
// FCS-less instance, checked against a frame-level reference model.
module tb_jellyvl_etherneco_packet_tx_gen;

  localparam int PL = 6;
  localparam int HB = 2;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_UNDER  = 1;
  localparam int MODE_OVER   = 2;
  localparam int MODE_CANCEL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start_req = 1'b0;
  logic        sel = 1'b0;
  logic        cancel = 1'b0;
  logic [15:0] param_length = '0;
  logic [15:0] param_header = '0;
  logic        s_payload_last = 1'b0;
  logic        s_payload_valid = 1'b0;
  logic [7:0]  s_payload_data = '0;
  logic        m_tx_ready = 1'b1;

  logic a_start, a_tx_start, a_busy, a_done, a_pready, a_first, a_last, a_error, a_valid;
  logic b_start, b_tx_start, b_busy, b_done, b_pready, b_first, b_last, b_error, b_valid;
  logic [7:0] a_data, b_data;

  assign a_start = start_req && !sel;
  assign b_start = start_req && sel;

  jellyvl_etherneco_packet_tx_gen dut_a (
    .clk(clk), .reset(reset), .start(a_start), .cancel(cancel),
    .param_length(param_length), .param_header(param_header),
    .tx_start(a_tx_start), .busy(a_busy), .done(a_done),
    .s_payload_last(s_payload_last), .s_payload_data(s_payload_data),
    .s_payload_valid(s_payload_valid), .s_payload_ready(a_pready),
    .m_tx_first(a_first), .m_tx_last(a_last), .m_tx_error(a_error),
    .m_tx_data(a_data), .m_tx_valid(a_valid), .m_tx_ready(m_tx_ready)
  );

  jellyvl_etherneco_packet_tx_gen #(.MIN_PAYLOAD(8), .FCS_ENABLE(0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .cancel(cancel),
    .param_length(param_length), .param_header(param_header),
    .tx_start(b_tx_start), .busy(b_busy), .done(b_done),
    .s_payload_last(s_payload_last), .s_payload_data(s_payload_data),
    .s_payload_valid(s_payload_valid), .s_payload_ready(b_pready),
    .m_tx_first(b_first), .m_tx_last(b_last), .m_tx_error(b_error),
    .m_tx_data(b_data), .m_tx_valid(b_valid), .m_tx_ready(m_tx_ready)
  );

  logic       o_tx_start, o_busy, o_done, o_pready, o_first, o_last, o_error, o_valid;
  logic [7:0] o_data;
  assign o_tx_start = sel ? b_tx_start : a_tx_start;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_done     = sel ? b_done     : a_done;
  assign o_pready   = sel ? b_pready   : a_pready;
  assign o_first    = sel ? b_first    : a_first;
  assign o_last     = sel ? b_last     : a_last;
  assign o_error    = sel ? b_error    : a_error;
  assign o_valid    = sel ? b_valid    : a_valid;
  assign o_data     = sel ? b_data     : a_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  pl [64];
  logic [31:0] crc_tbl [256];
  logic [7:0]  exp_q [$];
  bit          exp_abort;
  logic [7:0]  got_d [$];
  bit          got_f [$];
  bit          got_l [$];
  bit          got_e [$];

  // Byte-wise table CRC (poly 04C11DB7, MSB first, init all ones, no final xor).
  function automatic logic [31:0] crc_model(input logic [7:0] q[$], input int from);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < q.size(); i++)
      c = {c[23:0], 8'h00} ^ crc_tbl[c[31:24] ^ q[i]];
    return c;
  endfunction

  function automatic void build_expected(input int n, input int k, input int minp,
                                         input int fcs, input int mode, input int prm);
    int p;
    int abort_at;
    logic [31:0] c;
    exp_q.delete();
    for (int i = 0; i < PL; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'((n - 1) & 255));
    exp_q.push_back(8'(((n - 1) >> 8) & 255));
    for (int h = 0; h < HB; h++) exp_q.push_back(param_header[8*h +: 8]);
    p = (n > minp) ? n : minp;
    for (int i = 0; i < p; i++) exp_q.push_back((i < k) ? pl[i] : 8'h00);
    if (fcs != 0) begin
      c = crc_model(exp_q, PL + 1);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[23:16]);
      exp_q.push_back(c[31:24]);
    end
    abort_at = -1;
    if (mode == MODE_UNDER) abort_at = PL + 3 + HB + prm;
    if (mode == MODE_OVER)  abort_at = PL + 3 + HB + n - 1;
    if (mode == MODE_CANCEL && (prm + 1 < exp_q.size() - 1)) abort_at = prm + 1;
    exp_abort = (abort_at >= 0);
    if (exp_abort) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(8'h00);
    end
  endfunction

  task automatic run_frame(input int n, input int k, input int minp, input int fcs,
                           input int mode, input int prm, input bit rnd, input string name);
    int idx = 0;
    int ndone = 0;
    int cyc = 0;
    int idle_after = 0;
    int stall_bad = 0;
    int bad = 0;
    int first_bad = -1;
    bit started = 0;
    bit prev_stall = 0;
    logic [11:0] prev_o = '0;
    int last_i;
    build_expected(n, k, minp, fcs, mode, prm);
    got_d.delete(); got_f.delete(); got_l.delete(); got_e.delete();
    param_length = 16'(n - 1);
    while (idle_after < 3 && cyc < 3000) begin
      @(negedge clk);
      start_req  = !started;
      m_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == MODE_UNDER) s_payload_valid = (idx < prm);
      else                    s_payload_valid = (idx < k);
      s_payload_last = (mode == MODE_NORMAL || mode == MODE_CANCEL) && (idx == k - 1);
      s_payload_data = pl[idx % 64];
      cancel = (mode == MODE_CANCEL) && o_valid && (got_d.size() == prm);
      #1;
      if (started && !o_busy) idle_after++;
      if (o_tx_start) started = 1;
      if (prev_stall && ({o_valid, o_first, o_last, o_error, o_data} !== prev_o)) stall_bad++;
      prev_stall = o_valid && !m_tx_ready;
      prev_o     = {o_valid, o_first, o_last, o_error, o_data};
      if (o_valid && m_tx_ready) begin
        got_d.push_back(o_data);
        got_f.push_back(o_first);
        got_l.push_back(o_last);
        got_e.push_back(o_error);
      end
      if (s_payload_valid && o_pready) idx++;
      if (o_done) ndone++;
      cyc++;
    end
    start_req = 0; cancel = 0; s_payload_valid = 0; s_payload_last = 0; m_tx_ready = 1;

    n_checks++;
    if (idle_after < 3) $display("FAIL %s timeout: busy still %0b after %0d cycles, required idle", name, o_busy, cyc);
    else n_pass++;

    n_checks++;
    if (got_d.size() != exp_q.size())
      $display("FAIL %s beats: got %0d beats, expected %0d", name, got_d.size(), exp_q.size());
    else n_pass++;

    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++)
      if (got_d[i] !== exp_q[i]) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++;
    if (bad != 0)
      $display("FAIL %s data: %0d wrong bytes, first at beat %0d got %02h expected %02h",
               name, bad, first_bad, got_d[first_bad], exp_q[first_bad]);
    else n_pass++;

    bad = 0;
    last_i = exp_q.size() - 1;
    for (int i = 0; i < got_d.size(); i++)
      if (got_f[i] != (i == 0) || got_l[i] != (i == last_i) || got_e[i] != (exp_abort && i == last_i))
        bad++;
    n_checks++;
    if (bad != 0) $display("FAIL %s flags: %0d beats with wrong first/last/error, expected 0", name, bad);
    else n_pass++;

    n_checks++;
    if (ndone != (exp_abort ? 0 : 1))
      $display("FAIL %s done: pulsed %0d times, expected %0d", name, ndone, exp_abort ? 0 : 1);
    else n_pass++;

    if (rnd) begin
      n_checks++;
      if (stall_bad != 0) $display("FAIL %s stall: output changed %0d times while stalled, expected 0", name, stall_bad);
      else n_pass++;
    end
  endtask

  task automatic load_fixed_payload();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    param_header = 16'h0201;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
    param_header = 16'($urandom);
  endtask

  task automatic test_crc_model();
    logic [7:0] q [$];
    logic [31:0] c;
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    c = crc_model(q, 0);
    n_checks++;
    if (c !== 32'h0376_E6E7) $display("FAIL crc_model: got %08h expected 0376e6e7", c);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({a_valid, a_first, a_last, a_error, a_busy, a_done, a_pready, a_tx_start} !== 8'h00)
      $display("FAIL reset_a: outputs %b expected 00000000",
               {a_valid, a_first, a_last, a_error, a_busy, a_done, a_pready, a_tx_start});
    else n_pass++;
    n_checks++;
    if ({b_valid, b_first, b_last, b_error, b_busy, b_done, b_pready, b_tx_start} !== 8'h00)
      $display("FAIL reset_b: outputs %b expected 00000000",
               {b_valid, b_first, b_last, b_error, b_busy, b_done, b_pready, b_tx_start});
    else n_pass++;
    reset = 0;
  endtask

  task automatic test_basic();
    load_fixed_payload();
    run_frame(4, 4, 0, 1, MODE_NORMAL, 0, 0, "basic");
    n_checks++;
    if (got_d.size() != 19) $display("FAIL basic_len: got %0d beats expected 19", got_d.size());
    else n_pass++;
  endtask

  task automatic test_random_ready();
    int n;
    load_fixed_payload();
    run_frame(4, 4, 0, 1, MODE_NORMAL, 0, 1, "stall_fixed");
    for (int t = 0; t < 4; t++) begin
      randomize_frame();
      n = $urandom_range(1, 20);
      run_frame(n, n, 0, 1, MODE_NORMAL, 0, 1, "stall_random");
    end
  endtask

  task automatic test_early_last();
    load_fixed_payload();
    run_frame(4, 2, 0, 1, MODE_NORMAL, 0, 0, "early_last");
    n_checks++;
    if (got_d.size() < 15 || got_d[13] !== 8'h00 || got_d[14] !== 8'h00)
      $display("FAIL early_last_pad: got %0d beats, pad bytes not 00 00", got_d.size());
    else n_pass++;
  endtask

  task automatic test_min_pad();
    int n;
    sel = 1;
    randomize_frame();
    run_frame(1, 1, 8, 0, MODE_NORMAL, 0, 0, "min_pad");
    n_checks++;
    if (got_d.size() != 19) $display("FAIL min_pad_len: got %0d beats expected 19", got_d.size());
    else n_pass++;
    n = $urandom_range(2, 12);
    run_frame(n, n, 8, 0, MODE_NORMAL, 0, 1, "min_pad_random");
    run_frame(6, 3, 8, 0, MODE_NORMAL, 0, 0, "min_pad_early");
    sel = 0;
  endtask

  task automatic test_errors();
    randomize_frame();
    run_frame(5, 5, 0, 1, MODE_UNDER, 2, 0, "underrun");
    run_frame(3, 3, 0, 1, MODE_OVER, 0, 0, "overrun");
    run_frame(4, 4, 0, 1, MODE_NORMAL, 0, 0, "after_error");
  endtask

  task automatic test_cancel();
    int bad = 0;
    randomize_frame();
    run_frame(4, 4, 0, 1, MODE_CANCEL, PL + 3, 0, "cancel_header");
    run_frame(4, 4, 0, 1, MODE_CANCEL, 17, 0, "cancel_final");
    @(negedge clk);
    cancel = 1; start_req = 1;
    repeat (4) begin
      #1;
      if (a_tx_start || a_valid || a_busy) bad++;
      @(negedge clk);
    end
    cancel = 0; start_req = 0;
    #1;
    if (a_valid || a_busy) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL cancel_idle: %0d cycles with activity, expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    load_fixed_payload();
    param_length = 16'd3;
    @(negedge clk);
    start_req = 1; m_tx_ready = 1;
    @(negedge clk);
    start_req = 0;
    repeat (8) @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_valid, a_first, a_last, a_error, a_busy, a_done, a_pready} !== 7'h00)
      $display("FAIL reset_mid: outputs %b expected 0000000",
               {a_valid, a_first, a_last, a_error, a_busy, a_done, a_pready});
    else n_pass++;
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (a_valid || a_error) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_mid_quiet: %0d beats after reset, expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    for (int t = 0; t < 2; t++) begin
      randomize_frame();
      n = $urandom_range(1, 16);
      run_frame(n, n, 0, 1, MODE_NORMAL, 0, t == 1, "back_to_back");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i) << 24;
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      crc_tbl[i] = c;
    end
    test_crc_model();
    test_reset();
    test_basic();
    test_random_ready();
    test_early_last();
    test_min_pad();
    test_errors();
    test_cancel();
    test_reset_midframe();
    test_basic();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
